// File: rtl/shifter_pipe_param.sv
// shifter_pipe_param: parametrised, pipelined barrel shifter with valid/ready flow control.
//
// One register stage per shift level. Stage k rotates or shifts by 2^k when shift-amount bit k
// is set, otherwise it passes the value through. Latency is LEVELS cycles and throughput is one
// op per cycle. Backpressure ripples combinationally from out_ready back to in_ready.
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready        input handshake
//   in_data, in_shamt, in_op   operand, shift amount, op (000 ROL, 001 SLL, 010 ROR, 011 SRL,
//                              100 SRA, others illegal)
//   in_tag                     opaque tag carried with the op
//   out_valid / out_ready      output handshake
//   out_data, out_tag          result and its tag
//   out_illegal                op code was illegal; out_data is the unmodified operand
//   out_zero                   result equals zero (only with SHIFTER_PIPE_ZERO_FLAG_EN defined)
//
// Optional feature macro: SHIFTER_PIPE_ZERO_FLAG_EN adds the registered out_zero flag.
module shifter_pipe_param #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned TAG_W  = 4,
  localparam int unsigned LEVELS = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [LEVELS-1:0] in_shamt,
  input  logic [2:0]        in_op,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [TAG_W-1:0]  out_tag,
`ifdef SHIFTER_PIPE_ZERO_FLAG_EN
  output logic              out_zero,
`endif
  output logic              out_illegal
);

  localparam logic [2:0] OpRol = 3'b000;
  localparam logic [2:0] OpSll = 3'b001;
  localparam logic [2:0] OpRor = 3'b010;
  localparam logic [2:0] OpSrl = 3'b011;
  localparam logic [2:0] OpSra = 3'b100;

  // Per-stage inputs (w_*_in[k] feeds stage k) and the shifted result of each stage.
  logic [WIDTH-1:0]  w_data_in  [LEVELS];
  logic [LEVELS-1:0] w_shamt_in [LEVELS];
  logic [2:0]        w_op_in    [LEVELS];
  logic              w_sign_in  [LEVELS];
  logic [TAG_W-1:0]  w_tag_in   [LEVELS];
  logic              w_ill_in   [LEVELS];
  logic              w_vld_in   [LEVELS];
  logic [WIDTH-1:0]  w_data_sh  [LEVELS];
  logic [LEVELS-1:0] w_load;
  logic [LEVELS-1:0] w_full;
  logic              w_in_ill;

  // Stage registers. The last stage has no use for shamt, op or sign, so those stop one short.
  logic              r_valid [LEVELS];
  logic [WIDTH-1:0]  r_data  [LEVELS];
  logic [TAG_W-1:0]  r_tag   [LEVELS];
  logic              r_ill   [LEVELS];
  logic [LEVELS-1:0] r_shamt [LEVELS-1];
  logic [2:0]        r_op    [LEVELS-1];
  logic              r_sign  [LEVELS-1];

  // Illegal ops travel with a zero shift amount so every stage passes the operand through.
  assign w_in_ill      = (in_op > OpSra);
  assign w_data_in[0]  = in_data;
  assign w_shamt_in[0] = w_in_ill ? '0 : in_shamt;
  assign w_op_in[0]    = in_op;
  assign w_sign_in[0]  = in_data[WIDTH-1];
  assign w_tag_in[0]   = in_tag;
  assign w_ill_in[0]   = w_in_ill;
  assign w_vld_in[0]   = in_valid;

  assign in_ready = w_load[0];

  for (genvar k = 0; k < LEVELS; k++) begin : g_stage
    localparam int unsigned Sh = 2 ** k;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_fill;

    assign w_full[k] = r_valid[k];
    // Stage k loads when any stage from k to the end has room, or the consumer drains.
    assign w_load[k] = out_ready | ~(&w_full[LEVELS-1:k]);

    if (k > 0) begin : g_link
      assign w_data_in[k]  = r_data[k-1];
      assign w_shamt_in[k] = r_shamt[k-1];
      assign w_op_in[k]    = r_op[k-1];
      assign w_sign_in[k]  = r_sign[k-1];
      assign w_tag_in[k]   = r_tag[k-1];
      assign w_ill_in[k]   = r_ill[k-1];
      assign w_vld_in[k]   = r_valid[k-1];
    end

    always_comb begin
      w_fill = w_sign_in[k] ? ~({WIDTH{1'b1}} >> Sh) : '0;
      w_res  = w_data_in[k];
      if (w_shamt_in[k][k]) begin
        case (w_op_in[k])
          OpRol:   w_res = (w_data_in[k] << Sh) | (w_data_in[k] >> (WIDTH - Sh));
          OpSll:   w_res = w_data_in[k] << Sh;
          OpRor:   w_res = (w_data_in[k] >> Sh) | (w_data_in[k] << (WIDTH - Sh));
          OpSrl:   w_res = w_data_in[k] >> Sh;
          OpSra:   w_res = (w_data_in[k] >> Sh) | w_fill;
          default: w_res = w_data_in[k];
        endcase
      end
    end
    assign w_data_sh[k] = w_res;

    // Payload only updates on a real op so a drained stage keeps its last result.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_valid[k] <= 1'b0;
        r_data[k]  <= '0;
        r_tag[k]   <= '0;
        r_ill[k]   <= 1'b0;
      end else if (w_load[k]) begin
        r_valid[k] <= w_vld_in[k];
        if (w_vld_in[k]) begin
          r_data[k] <= w_res;
          r_tag[k]  <= w_tag_in[k];
          r_ill[k]  <= w_ill_in[k];
        end
      end
    end

    if (k < LEVELS - 1) begin : g_ctl
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_shamt[k] <= '0;
          r_op[k]    <= '0;
          r_sign[k]  <= 1'b0;
        end else if (w_load[k] && w_vld_in[k]) begin
          r_shamt[k] <= w_shamt_in[k];
          r_op[k]    <= w_op_in[k];
          r_sign[k]  <= w_sign_in[k];
        end
      end
    end
  end

  assign out_valid   = r_valid[LEVELS-1];
  assign out_data    = r_data[LEVELS-1];
  assign out_tag     = r_tag[LEVELS-1];
  assign out_illegal = r_ill[LEVELS-1];

`ifdef SHIFTER_PIPE_ZERO_FLAG_EN
  logic r_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero <= 1'b0;
    end else if (w_load[LEVELS-1] && w_vld_in[LEVELS-1]) begin
      r_zero <= (w_data_sh[LEVELS-1] == '0);
    end
  end

  assign out_zero = r_zero;
`endif

endmodule

// File: tb/tb_shifter_pipe_param.sv
module tb_shifter_pipe_param;

  localparam int unsigned W  = 16;
  localparam int unsigned TW = 4;
  localparam int unsigned L  = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [L-1:0]  in_shamt;
  logic [2:0]    in_op;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [TW-1:0] out_tag;
  logic          out_illegal;
`ifdef SHIFTER_PIPE_ZERO_FLAG_EN
  logic          out_zero;
`endif

  shifter_pipe_param #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_shamt   (in_shamt),
    .in_op      (in_op),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_tag    (out_tag),
`ifdef SHIFTER_PIPE_ZERO_FLAG_EN
    .out_zero   (out_zero),
`endif
    .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  d;
    logic [TW-1:0] t;
    logic          il;
    int            cyc;
  } exp_t;

  exp_t          sb[$];
  exp_t          e;
  int            n_vec = 0;
  int            n_err = 0;
  int            n_acc = 0;
  int            cyc   = 0;
  bit            chk_lat = 1'b1;
  bit            rnd_done = 1'b0;
  bit            hold_pend = 1'b0;
  logic [W-1:0]  h_d;
  logic [TW-1:0] h_t;
  logic          h_il;
  logic [W-1:0]  held;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference result straight from the op definitions, full shift amount at once.
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int s,
                                             input logic [2:0] op);
    logic [W-1:0] r;
    case (op)
      3'd0:    r = (d << s) | (d >> (W - s));
      3'd1:    r = d << s;
      3'd2:    r = (d >> s) | (d << (W - s));
      3'd3:    r = d >> s;
      3'd4:    r = W'($signed(d) >>> s);
      default: r = d;
    endcase
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_data", 32'(out_data), 32'(h_d));
        check("hold_tag", 32'(out_tag), 32'(h_t));
        check("hold_ill", 32'(out_illegal), 32'(h_il));
      end
      hold_pend = out_valid && !out_ready;
      h_d  = out_data;
      h_t  = out_tag;
      h_il = out_illegal;
      if (in_valid && in_ready) begin
        e.il  = (in_op > 3'd4);
        e.d   = ref_shift(in_data, int'(in_shamt), in_op);
        e.t   = in_tag;
        e.cyc = cyc;
        sb.push_back(e);
        n_acc++;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_out", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("data", 32'(out_data), 32'(e.d));
          check("tag", 32'(out_tag), 32'(e.t));
          check("illegal", 32'(out_illegal), 32'(e.il));
`ifdef SHIFTER_PIPE_ZERO_FLAG_EN
          check("zero", 32'(out_zero), 32'(e.d == '0));
`endif
          if (chk_lat) check("latency", 32'(cyc - e.cyc), L);
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input logic [L-1:0] s, input logic [2:0] op,
                      input logic [TW-1:0] t);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = s;
    in_op    = op;
    in_tag   = t;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_op     = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_tag", 32'(out_tag), 32'd0);
    check("rst_ill", 32'(out_illegal), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Rotate with wrap, then back-to-back SRA / SRL / ROR.
    send(16'h8001, 4'd1, 3'b000, 4'd3);
    send(16'h8000, 4'd15, 3'b100, 4'd1);
    send(16'h8000, 4'd15, 3'b011, 4'd2);
    send(16'h0001, 4'd4, 3'b010, 4'd4);
    drain();

    // Illegal op passes operand through, following legal op is unaffected.
    send(16'h1234, 4'd5, 3'b111, 4'd7);
    send(16'h1234, 4'd4, 3'b001, 4'd8);
    send(16'h0001, 4'd15, 3'b001, 4'd9);
    send(16'h0100, 4'd8, 3'b001, 4'd10);
    send(16'hBEEF, 4'd0, 3'b100, 4'd11);
    drain();

    // Backpressure: only LEVELS ops fit, output holds, then everything drains in order.
    chk_lat   = 1'b0;
    out_ready = 1'b0;
    n_acc     = 0;
    fork
      begin
        for (int t = 0; t < 6; t++) send(W'(16'h0F00 + t), L'(t), 3'(t % 5), TW'(t));
      end
      begin
        repeat (10) @(negedge clk);
        #1;
        check("fill_count", 32'(n_acc), L);
        check("fill_in_ready", 32'(in_ready), 32'd0);
        check("fill_out_valid", 32'(out_valid), 32'd1);
        held = out_data;
        repeat (3) @(negedge clk);
        check("fill_held", 32'(out_data), 32'(held));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three ops in flight: discarded, outputs clear asynchronously.
    chk_lat = 1'b1;
    send(16'hAAAA, 4'd1, 3'b001, 4'd1);
    send(16'h5555, 4'd2, 3'b011, 4'd2);
    send(16'hF0F0, 4'd3, 3'b000, 4'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_data", 32'(out_data), 32'd0);
    check("arst_tag", 32'(out_tag), 32'd0);
    check("arst_ill", 32'(out_illegal), 32'd0);
`ifdef SHIFTER_PIPE_ZERO_FLAG_EN
    check("arst_zero", 32'(out_zero), 32'd0);
`endif
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(16'h00C3, 4'd6, 3'b000, 4'd5);
    drain();

    // Random ops, random gaps, random backpressure.
    chk_lat = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send(W'($urandom), L'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
               TW'($urandom));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shifter_pipe_param.md
Name: shifter_pipe_param

Overview:
- Parametrised, pipelined barrel shifter for the datapath; next generation of the 16-bit single-level shifter cells.
- Generalised to WIDTH bits with log2(WIDTH) shift levels, one register stage per level.
- Adds arithmetic shift right, a per-operation tag, and valid/ready flow control with full backpressure.
- Sits between operand read and writeback; the ALU issues shift ops into it.

Parameters:
- WIDTH, 16, data width; power of two, >= 4.
- TAG_W, 4, width of the opaque tag carried alongside each operation.
- LEVELS, $clog2(WIDTH), derived localparam, not overridable; number of shift levels and register stages.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input operation valid.
- in_ready  out  1  block can accept an input this cycle.
- in_data  in  WIDTH  operand.
- in_shamt  in  LEVELS  shift amount, 0..WIDTH-1.
- in_op  in  3  000 ROL, 001 SLL, 010 ROR, 011 SRL, 100 SRA, others illegal.
- in_tag  in  TAG_W  passed through unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  shifted result.
- out_tag  out  TAG_W  tag of the result.
- out_illegal  out  1  the op code was illegal; out_data equals the unmodified operand.

Behaviour:
- Pipeline structure: stage k (k = 0..LEVELS-1) shifts or rotates by 2^k when shamt bit k is set, else passes the value through.
- Each stage registers data, remaining shamt, op, tag, illegal bit and a valid bit.
- Latency: exactly LEVELS cycles from input handshake to out_valid, with no stalls (4 cycles at WIDTH=16).
- Throughput: 1 op per cycle.
- Handshake:
  - Input transfer occurs when in_valid & in_ready; output transfer occurs when out_valid & out_ready.
  - Stage k loads when it is empty or stage k+1 loads this cycle. The last stage loads when it is empty or out_ready=1.
  - in_ready = stage 0 loads-enable; it is combinational from out_ready through the stage chain.
  - A stalled stage holds all of its fields stable.
  - out_data, out_tag and out_illegal are stable while out_valid=1 & out_ready=0.
- Fill semantics:
  - SLL and SRL fill vacated bits with 0.
  - SRA fills with in_data[WIDTH-1], sampled at input and held through all levels.
  - ROL and ROR wrap bits around.
- Illegal op: out_illegal=1 and shift amount treated as 0.
- shamt=0: out_data = in_data for every op.
- Reset: asynchronous clear of all valid bits; data, tag and illegal regs reset to 0.
  - After reset: out_valid=0, out_data=0, out_tag=0, out_illegal=0.
  - in_ready=1 on the first clock after reset deasserts.
  - In-flight ops are discarded; no partial result is ever presented.
- Simultaneous accept and drain on a full pipe: allowed; occupancy stays at LEVELS.
- in_valid with no in_ready: the op is not captured, and the producer must hold it.

Optional Feature:
- Macro: SHIFTER_PIPE_ZERO_FLAG_EN.
- Defined:
  - Adds port out_zero (out, 1), computed in the last stage as out_data == 0.
  - Registered with the result and obeys the same hold rules.
  - Resets to 0.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan (WIDTH=16):
- ROL 0x8001 by 1, tag 3: out_data 0x0003, out_tag 3, out_valid exactly 4 cycles after accept.
- SRA 0x8000 by 15, then SRL 0x8000 by 15, then ROR 0x0001 by 4, back-to-back: 0xFFFF, 0x0001, 0x1000 on consecutive cycles.
- Illegal op 111 on 0x1234 by 5: out_data 0x1234, out_illegal=1; legal SLL 0x1234 by 4 next gives 0x2340, out_illegal=0.
- Fill pipe with 6 ops while out_ready=0: 4 accepted, then in_ready=0 and out_data held constant; release out_ready and all 6 results appear in order with tags 0..5.
- Assert rst_n=0 for one cycle with 3 ops in flight: out_valid=0 immediately (async), outputs 0; a new op after release completes normally.
- With SHIFTER_PIPE_ZERO_FLAG_EN: SLL 0x0001 by 15 gives out_zero=0; SLL 0x0100 by 8 gives 0x0000 with out_zero=1.
